serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: el  input  1  active-low enable; el=1 freezes all state.
REQ-005 SHALL have port: start  input  1  request to begin a subtraction.
REQ-006 SHALL have port: A  input  WIDTH  minuend, sampled on accepted start.
REQ-007 SHALL have port: B  input  WIDTH  subtrahend, sampled on accepted start.
REQ-008 SHALL have port: bi  input  1  initial borrow-in, sampled on accepted start.
REQ-009 SHALL have port: D  output  WIDTH  registered difference A-B-bi (mod 2^WIDTH).
REQ-010 SHALL have port: bo  output  1  registered final borrow-out.
REQ-011 SHALL have port: busy  output  1  high while bits are being processed.
REQ-012 SHALL have port: done  output  1  one-cycle pulse, D/bo newly valid.
REQ-013 SHALL have port: d_bit  output  1  registered per-bit difference of last processed bit.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; busy=1 only in SHIFT, done=1 only in DONE.
REQ-015 SHALL accept start only when start=1, el=0 and state is IDLE or DONE: load A, B into internal shift registers, load bi into borrow register, clear bit counter, enter SHIFT.
REQ-016 SHALL ignore start while in SHIFT; the in-flight operation and its operands are unaffected.
REQ-017 SHALL, on each SHIFT edge with el=0, process LSB bits a, b and borrow br: diff = a^b^br, next borrow = (~a&b)|(~(a^b)&br).
REQ-018 SHALL shift operand registers right by one, shift diff into result register from the MSB end, update borrow register and d_bit, and increment counter each processed bit.
REQ-019 SHALL process exactly WIDTH bits LSB-first; after the bit with counter = WIDTH-1, load D from result register and bo from borrow register, and enter DONE.
REQ-020 SHALL have latency: start accepted at edge k, no stalls -> done=1 in the cycle following edge k+WIDTH; D and bo change only at edge k+WIDTH.
REQ-021 SHALL leave DONE after one cycle: to SHIFT if start accepted there (back-to-back, no idle cycle), else to IDLE.
REQ-022 SHALL hold D and bo stable from completion until the next completion.
REQ-023 SHALL, with el=1 in any state, hold state, counter, shift registers, borrow, D, bo, d_bit; done stays asserted if stalled in DONE; each stalled cycle adds one cycle to latency.
REQ-024 SHALL produce D = (A - B - bi) mod 2^WIDTH and bo = 1 exactly when A < B + bi (unsigned).

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-operation, immediately clear state to IDLE, counter, shift registers, borrow, D=0, bo=0, busy=0, done=0, d_bit=0, independent of clk.
REQ-026 SHALL resume normal operation at the first rising clk edge after rst_n returns high; an aborted operation never produces done.

Verification
REQ-027 SHALL cover: WIDTH=8, A=0x05, B=0x03, bi=0 -> done 8 edges after start, D=0x02, bo=0, busy high exactly 8 cycles.
REQ-028 SHALL cover: A=0x03, B=0x05, bi=0 -> D=0xFE, bo=1; A=0x00, B=0x00, bi=1 -> D=0xFF, bo=1; A=0xFF, B=0xFF, bi=1 -> D=0xFF, bo=1.
REQ-029 SHALL cover: el=1 for 3 cycles during SHIFT of A=0x80, B=0x01 -> done 11 edges after start, D=0x7F, bo=0.
REQ-030 SHALL cover: start pulsed mid-operation with A=0xAA, B=0x11 -> ignored, original result delivered; start held during DONE -> new operation begins with no idle cycle.
REQ-031 SHALL cover: rst_n low at bit 4 of an operation -> all outputs 0 immediately, no done pulse; subsequent A=0x10, B=0x01 -> D=0x0F, bo=0.
REQ-032 SHALL cover: exhaustive 4-bit run (WIDTH=4, all A, B, bi) compared against A-B-bi reference model.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bi one bit per cycle, LSB first,
// with an active-low enable that freezes all state when high.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             el,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bi,
  output logic [WIDTH-1:0] D,
  output logic             bo,
  output logic             busy,
  output logic             done,
  output logic             d_bit
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic load_c, step_c, last_c;
  logic diff_c, borrow_c;

  // One full-subtractor cell operating on the current LSBs
  assign diff_c   = a_sr[0] ^ b_sr[0] ^ br;
  assign borrow_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last_c   = (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control; el=1 holds everything
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    step_c  = 1'b0;
    if (!el) begin
      case (state)
        IDLE: begin
          if (start) begin
            load_c  = 1'b1;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          step_c = 1'b1;
          if (last_c) begin
            state_n = DONE;
          end
        end
        DONE: begin
          if (start) begin
            load_c  = 1'b1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand/result shift registers, borrow, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      bo    <= 1'b0;
      d_bit <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_n == SHIFT);
      done <= (state_n == DONE);
      if (load_c) begin
        a_sr <= A;
        b_sr <= B;
        br   <= bi;
        cnt  <= '0;
      end else if (step_c) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= {diff_c, r_sr[WIDTH-1:1]};
        br    <= borrow_c;
        d_bit <= diff_c;
        cnt   <= cnt + CW'(1);
        if (last_c) begin
          // Final bit goes straight into D alongside the accumulated bits
          D  <= {diff_c, r_sr[WIDTH-1:1]};
          bo <= borrow_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed 8-bit vectors plus an
// exhaustive 4-bit sweep on a second instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic el = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bi8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       bo8, busy8, done8, dbit8;

  logic       start4 = 1'b0, bi4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, d4;
  logic       bo4, busy4, done4, dbit4;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .el(el), .start(start8), .A(a8), .B(b8), .bi(bi8),
    .D(d8), .bo(bo8), .busy(busy8), .done(done8), .d_bit(dbit8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .el(el), .start(start4), .A(a4), .B(b4), .bi(bi4),
    .D(d4), .bo(bo4), .busy(busy4), .done(done4), .d_bit(dbit4)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int done_cnt8 = 0, done_cnt4 = 0, done_cyc8 = 0, busy_cnt8 = 0, acc8 = 0;
  logic done8_q = 1'b0, done4_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop expected result on each new done pulse
  always @(negedge clk) begin
    logic [8:0] e;
    if (busy8) busy_cnt8++;
    if (done8 && !done8_q) begin
      done_cnt8++;
      done_cyc8 = cyc;
      if (q8.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done8: got D=0x%0h bo=%0b, required no done", d8, bo8);
      end else begin
        e = q8.pop_front();
        check("result8", {23'd0, bo8, d8}, {23'd0, e});
        check("d_bit8", {31'd0, dbit8}, {31'd0, e[7]});
      end
    end
    done8_q = done8;
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (done4 && !done4_q) begin
      done_cnt4++;
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done4: got D=0x%0h bo=%0b, required no done", d4, bo4);
      end else begin
        e = q4.pop_front();
        check("result4", {27'd0, bo4, d4}, {27'd0, e});
      end
    end
    done4_q = done4;
  end

  // Issue an 8-bit operation; called just after a rising edge
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [8:0] exp, input bit push);
    a8 = a; b8 = b; bi8 = bi; start8 = 1'b1;
    if (push) q8.push_back(exp);
    @(posedge clk); #1;
    acc8 = cyc;
    start8 = 1'b0;
    busy_cnt8 = 0;
  endtask

  task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    a4 = a; b4 = b; bi4 = bi; start4 = 1'b1;
    q4.push_back(5'({1'b0, a}) - 5'({1'b0, b}) - 5'({4'd0, bi}));
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done8(input int budget);
    int c0 = done_cnt8;
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt8 != c0) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL timeout8: got no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic wait_done4(input int budget);
    int c0 = done_cnt4;
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt4 != c0) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL timeout4: got no done within %0d cycles, required done", budget);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic bi; logic [8:0] exp; } vec_t;
  vec_t vecs[4] = '{
    '{8'h05, 8'h03, 1'b0, {1'b0, 8'h02}},
    '{8'h03, 8'h05, 1'b0, {1'b1, 8'hFE}},
    '{8'h00, 8'h00, 1'b1, {1'b1, 8'hFF}},
    '{8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}}
  };

  initial begin
    int lat;
    bit seen;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset8", {19'd0, d8, bo8, busy8, done8, dbit8}, 32'd0);
    check("reset4", {23'd0, d4, bo4, busy4, done4, dbit4}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with latency and busy-width checks
    foreach (vecs[i]) begin
      go8(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp, 1'b1);
      wait_done8(20);
      check("latency8", done_cyc8 - acc8, 8);
      check("busy_cycles8", busy_cnt8, 8);
    end

    // Three stalled cycles mid-operation
    go8(8'h80, 8'h01, 1'b0, {1'b0, 8'h7F}, 1'b1);
    repeat (2) @(posedge clk);
    #1 el = 1'b1;
    repeat (3) @(posedge clk);
    #1 el = 1'b0;
    wait_done8(20);
    check("latency_stall", done_cyc8 - acc8, 11);
    check("busy_stall", busy_cnt8, 11);

    // Start pulse during SHIFT is ignored
    go8(8'hAA, 8'h11, 1'b0, {1'b0, 8'h99}, 1'b1);
    repeat (3) @(posedge clk);
    #1 a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1'b1; break; end
    end
    check("done_seen_aa", {31'd0, seen}, 32'd1);
    // Start held in DONE: back-to-back operation
    a8 = 8'hC3; b8 = 8'h42; bi8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'h81});
    @(posedge clk); #1;
    lat = done_cyc8 - acc8;
    check("latency_aa", lat, 8);
    acc8 = cyc;
    start8 = 1'b0;
    busy_cnt8 = 0;
    check("busy_back_to_back", {31'd0, busy8}, 32'd1);
    wait_done8(20);
    check("latency_b2b", done_cyc8 - acc8, 8);

    // Reset during bit 4 aborts the operation
    go8(8'h5A, 8'h33, 1'b0, 9'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {19'd0, d8, bo8, busy8, done8, dbit8}, 32'd0);
    lat = done_cnt8;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    check("no_done_after_abort", done_cnt8, lat);
    #1;
    go8(8'h10, 8'h01, 1'b0, {1'b0, 8'h0F}, 1'b1);
    wait_done8(20);
    check("latency_after_reset", done_cyc8 - acc8, 8);

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          go4(4'(a), 4'(b), 1'(c));
          wait_done4(12);
        end

    repeat (2) @(posedge clk);
    check("queue8_empty", q8.size(), 0);
    check("queue4_empty", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
